// File: rtl/dl2_mem_pkg.sv
// Shared definitions for the DL2 burst memory model: FSM encoding, geometry helpers
// and the per-line beat count.
package dl2_mem_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_RD_LAT   = 3'd1,
      S_RD_BURST = 3'd2,
      S_WR_BURST = 3'd3,
      S_WR_LAT   = 3'd4,
      S_DONE     = 3'd5
   } dl2_mem_state_e;

   function automatic int line_ofs(input int line_bits);
      return $clog2(line_bits / 8);
   endfunction

   function automatic int sub_bits(input int line_bits, input int sb_log2);
      return line_bits >> sb_log2;
   endfunction

   function automatic int beat_count(input int sb_log2);
      return 1 << sb_log2;
   endfunction

   // Beats per line for the default DL2 geometry.
   localparam int DL2_MEM_BEATS = 1 << 2;

endpackage

// File: rtl/dl2_burst_memory_if.sv
// Request/response bundle between the DL2 D-side port (master) and the burst memory (slave).
interface dl2_burst_memory_if #(
   parameter int ADDR_BITS      = 32,
   parameter int LINE_BITS      = 512,
   parameter int SUBBLOCKS_LOG2 = 2
);
   localparam int SUB_BITS = LINE_BITS >> SUBBLOCKS_LOG2;

   // en_i/we_i are level requests held until acc_r_o/acc_w_o pulses; write beats follow
   // acc_w_o one per cycle, read beats are qualified by rvalid_o, ready_o ends every transaction.
   logic [ADDR_BITS-1:0]      addr_i;
   logic                      en_i;
   logic                      we_i;
   logic [SUBBLOCKS_LOG2-1:0] wstrb_i;
   logic [SUB_BITS-1:0]       wdata_i;
   logic [SUBBLOCKS_LOG2-1:0] rstrb_o;
   logic [SUB_BITS-1:0]       rdata_o;
   logic                      rvalid_o;
   logic                      ready_o;
   logic                      acc_r_o;
   logic                      acc_w_o;

   modport master (
      output addr_i, en_i, we_i, wstrb_i, wdata_i,
      input  rstrb_o, rdata_o, rvalid_o, ready_o, acc_r_o, acc_w_o
   );

   modport slave (
      input  addr_i, en_i, we_i, wstrb_i, wdata_i,
      output rstrb_o, rdata_o, rvalid_o, ready_o, acc_r_o, acc_w_o
   );
endinterface

// File: rtl/dl2_mem_array.sv
// 1R1W synchronous word array backing the burst memory; read data appears one cycle
// after the address. Deliberately not reset.
module dl2_mem_array #(
   parameter int AW = 14,
   parameter int DW = 128
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);
   logic [DW-1:0] mem_q [2**AW];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      rdata_o <= mem_q[raddr_i];
   end
endmodule

// File: rtl/dl2_burst_memory.sv
// DL2 main-memory model: fixed-latency strobed read bursts and one-beat-per-cycle write-backs.
// Optional statistics and beat-order checking are built when DL2_MEM_STATS_EN is defined.
module dl2_burst_memory
   import dl2_mem_pkg::*;
#(
   parameter int ADDR_BITS      = 32,
   parameter int LINE_BITS      = 512,
   parameter int SUBBLOCKS_LOG2 = 2,
   parameter int LINES_LOG2     = 12,
   parameter int RD_LATENCY     = 8,
   parameter int WR_LATENCY     = 4
) (
   input  logic           clk,
   input  logic           reset,
   dl2_burst_memory_if.slave bus,
   output dl2_mem_state_e state_o
`ifdef DL2_MEM_STATS_EN
   ,
   output logic [31:0]    stat_rd_o,
   output logic [31:0]    stat_wr_o,
   output logic [31:0]    stat_busy_o,
   output logic           stat_err_o
`endif
);
   localparam int LINE_OFS = line_ofs(LINE_BITS);
   localparam int SUB_BITS = sub_bits(LINE_BITS, SUBBLOCKS_LOG2);
   localparam int N        = beat_count(SUBBLOCKS_LOG2);
   localparam int WORD_AW  = LINES_LOG2 + SUBBLOCKS_LOG2;
   localparam int MAX_LAT  = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
   localparam int LAT_W    = $clog2(MAX_LAT) + 1;
   localparam logic [SUBBLOCKS_LOG2-1:0] LAST_BEAT = SUBBLOCKS_LOG2'(N - 1);

   dl2_mem_state_e            state_q, state_d;
   logic [LINES_LOG2-1:0]     line_q, line_d;
   logic [SUBBLOCKS_LOG2-1:0] beat_q, beat_d;
   logic [LAT_W-1:0]          lat_q, lat_d;
   logic                      acc_r_q, acc_r_d;
   logic                      acc_w_q, acc_w_d;

   logic                      mem_we;
   logic [WORD_AW-1:0]        mem_waddr, mem_raddr;
   logic [SUB_BITS-1:0]       mem_rdata;
   logic [SUBBLOCKS_LOG2-1:0] beat_inc;
   logic                      unused_addr;

   assign unused_addr = ^{bus.addr_i[ADDR_BITS-1:LINE_OFS+LINES_LOG2], bus.addr_i[LINE_OFS-1:0]};
   assign beat_inc    = beat_q + 1'b1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         line_q  <= '0;
         beat_q  <= '0;
         lat_q   <= '0;
         acc_r_q <= 1'b0;
         acc_w_q <= 1'b0;
      end else begin
         state_q <= state_d;
         line_q  <= line_d;
         beat_q  <= beat_d;
         lat_q   <= lat_d;
         acc_r_q <= acc_r_d;
         acc_w_q <= acc_w_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      line_d    = line_q;
      beat_d    = beat_q;
      lat_d     = lat_q;
      acc_r_d   = 1'b0;
      acc_w_d   = 1'b0;
      mem_we    = 1'b0;
      mem_waddr = {line_q, bus.wstrb_i};
      mem_raddr = {line_q, beat_q};
      case (state_q)
         S_IDLE: begin
            beat_d = '0;
            if (bus.we_i) begin
               line_d  = bus.addr_i[LINE_OFS+LINES_LOG2-1:LINE_OFS];
               acc_w_d = 1'b1;
               state_d = S_WR_BURST;
            end else if (bus.en_i) begin
               line_d  = bus.addr_i[LINE_OFS+LINES_LOG2-1:LINE_OFS];
               acc_r_d = 1'b1;
               lat_d   = LAT_W'(RD_LATENCY - 1);
               state_d = S_RD_LAT;
            end
         end
         // Last latency cycle presents beat 0's address so its data lines up with rvalid_o.
         S_RD_LAT: begin
            if (lat_q == '0) state_d = S_RD_BURST;
            else             lat_d   = lat_q - 1'b1;
         end
         S_RD_BURST: begin
            mem_raddr = {line_q, beat_inc};
            beat_d    = beat_inc;
            if (beat_q == LAST_BEAT) state_d = S_DONE;
         end
         // The acc_w_o cycle itself carries no beat; data starts on the following cycle.
         S_WR_BURST: begin
            if (!acc_w_q) begin
               mem_we = 1'b1;
               beat_d = beat_inc;
               if (beat_q == LAST_BEAT) begin
                  lat_d   = LAT_W'(WR_LATENCY - 1);
                  state_d = S_WR_LAT;
               end
            end
         end
         S_WR_LAT: begin
            if (lat_q == '0) state_d = S_DONE;
            else             lat_d   = lat_q - 1'b1;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   dl2_mem_array #(.AW(WORD_AW), .DW(SUB_BITS)) u_array (
      .clk     (clk),
      .we_i    (mem_we),
      .waddr_i (mem_waddr),
      .wdata_i (bus.wdata_i),
      .raddr_i (mem_raddr),
      .rdata_o (mem_rdata)
   );

   assign bus.rvalid_o = (state_q == S_RD_BURST);
   assign bus.rstrb_o  = bus.rvalid_o ? beat_q : '0;
   assign bus.rdata_o  = bus.rvalid_o ? mem_rdata : '0;
   assign bus.ready_o  = (state_q == S_DONE);
   assign bus.acc_r_o  = acc_r_q;
   assign bus.acc_w_o  = acc_w_q;
   assign state_o      = state_q;

`ifdef DL2_MEM_STATS_EN
   logic [31:0] rd_cnt_q, wr_cnt_q, busy_q;
   logic [N-1:0] seen_q;
   logic         err_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
         busy_q   <= '0;
         seen_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         if (acc_r_q) rd_cnt_q <= rd_cnt_q + 32'd1;
         if (acc_w_q) wr_cnt_q <= wr_cnt_q + 32'd1;
         if (state_q != S_IDLE) busy_q <= busy_q + 32'd1;
         if (state_q == S_IDLE) begin
            seen_q <= '0;
         end else if (mem_we) begin
            if (seen_q[bus.wstrb_i]) err_q <= 1'b1;
            seen_q[bus.wstrb_i] <= 1'b1;
         end
      end
   end

   assign stat_rd_o   = rd_cnt_q;
   assign stat_wr_o   = wr_cnt_q;
   assign stat_busy_o = busy_q;
   assign stat_err_o  = err_q;
`endif
endmodule

// File: tb/tb_dl2_burst_memory.sv
// Directed self-checking bench for dl2_burst_memory with a read-beat scoreboard and a
// line-aliasing memory model.
module tb_dl2_burst_memory;
   import dl2_mem_pkg::*;

   localparam int ADDR_BITS = 32;
   localparam int LINE_BITS = 512;
   localparam int SB_LOG2   = 2;
   localparam int LINES_L2  = 12;
   localparam int RD_LAT    = 8;
   localparam int WR_LAT    = 4;
   localparam int SUB_BITS  = LINE_BITS >> SB_LOG2;
   localparam int N         = DL2_MEM_BEATS;
   localparam int BW        = SUB_BITS + SB_LOG2;

   logic clk = 1'b0;
   logic reset = 1'b0;
   dl2_mem_state_e state;

   dl2_burst_memory_if #(.ADDR_BITS(ADDR_BITS), .LINE_BITS(LINE_BITS), .SUBBLOCKS_LOG2(SB_LOG2)) bus ();

`ifdef DL2_MEM_STATS_EN
   logic [31:0] stat_rd, stat_wr, stat_busy;
   logic        stat_err;
`endif

   dl2_burst_memory #(
      .ADDR_BITS(ADDR_BITS), .LINE_BITS(LINE_BITS), .SUBBLOCKS_LOG2(SB_LOG2),
      .LINES_LOG2(LINES_L2), .RD_LATENCY(RD_LAT), .WR_LATENCY(WR_LAT)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus.slave),
      .state_o (state)
`ifdef DL2_MEM_STATS_EN
      ,
      .stat_rd_o   (stat_rd),
      .stat_wr_o   (stat_wr),
      .stat_busy_o (stat_busy),
      .stat_err_o  (stat_err)
`endif
   );

   // clock / reset
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   logic [BW-1:0] exp_q[$];
   logic [SUB_BITS-1:0] model [int];
   bit sb_on = 1'b1;

   task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int widx(input logic [31:0] a, input int b);
      return int'((a >> 6) & 32'hFFF) * N + b;
   endfunction

   // scoreboard: compare every read beat against the queued expectation
   always @(negedge clk) begin
      if (reset && bus.rvalid_o && sb_on) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL rd_beat_unexpected observed=%h expected=none", {bus.rstrb_o, bus.rdata_o});
         end else begin
            check("rd_beat", {bus.rstrb_o, bus.rdata_o}, exp_q.pop_front());
         end
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic pick(input int which);
      case (which)
         0: return bus.acc_r_o;
         1: return bus.acc_w_o;
         2: return bus.ready_o;
         default: return bus.rvalid_o;
      endcase
   endfunction

   task automatic wait_sig(input string tag, input int which, input int budget, output int cycles);
      logic seen;
      seen = 1'b0;
      cycles = 0;
      while (!seen && cycles < budget) begin
         @(negedge clk);
         cycles++;
         seen = pick(which);
      end
      check(tag, seen, 1'b1);
   endtask

   task automatic push_line(input logic [31:0] addr);
      for (int b = 0; b < N; b++) exp_q.push_back({SB_LOG2'(b), model[widx(addr, b)]});
   endtask

   task automatic write_line(input logic [31:0] addr, input logic [N-1:0][SUB_BITS-1:0] data,
                             input logic [N-1:0][SB_LOG2-1:0] order);
      int c;
      tick();
      bus.addr_i = addr;
      bus.we_i   = 1'b1;
      wait_sig("wr_acc_w_seen", 1, 10, c);
      check("wr_acc_w_latency", c, 2);
      check("wr_no_acc_r", bus.acc_r_o, 1'b0);
      for (int i = 0; i < N; i++) begin
         tick();
         bus.we_i    = 1'b0;
         bus.wstrb_i = order[i];
         bus.wdata_i = data[order[i]];
         model[widx(addr, int'(order[i]))] = data[order[i]];
      end
      wait_sig("wr_ready_seen", 2, 20, c);
      check("wr_ready_latency", c, WR_LAT + 2);
      @(negedge clk);
      check("wr_ready_one_cycle", bus.ready_o, 1'b0);
   endtask

   task automatic read_line(input logic [31:0] addr);
      int c;
      tick();
      bus.addr_i = addr;
      bus.en_i   = 1'b1;
      push_line(addr);
      wait_sig("rd_acc_r_seen", 0, 10, c);
      tick();
      bus.en_i = 1'b0;
      wait_sig("rd_first_beat_seen", 3, 20, c);
      check("rd_first_beat_latency", c, RD_LAT);
      wait_sig("rd_ready_seen", 2, 10, c);
      check("rd_ready_after_burst", c, N);
      check("rd_queue_drained", exp_q.size(), 0);
      @(negedge clk);
      check("rd_ready_one_cycle", bus.ready_o, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0][SUB_BITS-1:0] d;
      logic [N-1:0][SB_LOG2-1:0] ord;
      int c;
      bit found;

      bus.addr_i  = '0;
      bus.en_i    = 1'b0;
      bus.we_i    = 1'b0;
      bus.wstrb_i = '0;
      bus.wdata_i = '0;

      // 1: reset held with a pending read
      bus.en_i = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("rst_outputs", {bus.rvalid_o, bus.ready_o, bus.acc_r_o, bus.acc_w_o, bus.rstrb_o}, '0);
         check("rst_rdata", bus.rdata_o, '0);
         check("rst_state", state, S_IDLE);
      end
      tick();
      reset = 1'b1;
      wait_sig("rst_release_acc_r", 0, 5, c);
      check("rst_release_acc_r_cycle", c, 2);
      sb_on = 1'b0;
      tick();
      bus.en_i = 1'b0;
      wait_sig("rst_first_read_ready", 2, 30, c);
      sb_on = 1'b1;

      // 2: in-order write then read back
      for (int i = 0; i < N; i++) d[i] = {4{32'hA0A0_0000 + 32'(i)}};
      ord = {2'd3, 2'd2, 2'd1, 2'd0};
      write_line(32'h40, d, ord);
      read_line(32'h40);

      // 3: simultaneous read and write; write wins, read follows after DONE
      for (int i = 0; i < N; i++) d[i] = {4{32'hC3C3_0000 + 32'(i)}};
      tick();
      bus.addr_i = 32'h80;
      bus.we_i   = 1'b1;
      bus.en_i   = 1'b1;
      wait_sig("both_acc_w_seen", 1, 10, c);
      check("both_no_acc_r", bus.acc_r_o, 1'b0);
      for (int i = 0; i < N; i++) begin
         tick();
         bus.we_i    = 1'b0;
         bus.wstrb_i = SB_LOG2'(i);
         bus.wdata_i = d[i];
         model[widx(32'h80, i)] = d[i];
      end
      wait_sig("both_wr_ready", 2, 20, c);
      push_line(32'h80);
      @(negedge clk);
      check("both_idle_no_acc_r", bus.acc_r_o, 1'b0);
      @(negedge clk);
      check("both_held_read_acc_r", bus.acc_r_o, 1'b1);
      tick();
      bus.en_i = 1'b0;
      wait_sig("both_rd_ready", 2, 30, c);
      check("both_queue_drained", exp_q.size(), 0);

      // 4: out-of-order write beats, random data
      for (int i = 0; i < N; i++) d[i] = {$urandom, $urandom, $urandom, $urandom};
      ord = {2'd2, 2'd0, 2'd1, 2'd3};
      write_line(32'h1C0, d, ord);
      read_line(32'h1C0);
`ifdef DL2_MEM_STATS_EN
      check("stats_no_err_yet", stat_err, 1'b0);
      ord = {2'd2, 2'd1, 2'd1, 2'd3};
      write_line(32'h200, d, ord);
      check("stats_err_repeat", stat_err, 1'b1);
      check("stats_rd_nonzero", (stat_rd != 0), 1'b1);
`endif

      // 5: aliasing across the line-index range
      for (int i = 0; i < N; i++) d[i] = {4{32'h5A00_0000 + 32'($urandom_range(0, 255))}};
      write_line(32'h40 + (32'h1 << (LINES_L2 + 6)), d, {2'd3, 2'd2, 2'd1, 2'd0});
      read_line(32'h40);

      // 6: async reset during read beat 1
      tick();
      bus.addr_i = 32'h80;
      bus.en_i   = 1'b1;
      push_line(32'h80);
      wait_sig("abort_acc_r", 0, 10, c);
      tick();
      bus.en_i = 1'b0;
      found = 1'b0;
      c = 0;
      while (!found && c < 20) begin
         @(negedge clk);
         c++;
         found = bus.rvalid_o && (bus.rstrb_o == 2'd1);
      end
      check("abort_beat1_seen", found, 1'b1);
      #2;
      reset = 1'b0;
      #1;
      check("abort_rvalid_drop", {bus.rvalid_o, bus.ready_o, bus.rstrb_o}, '0);
      check("abort_state", state, S_IDLE);
      exp_q.delete();
      repeat (2) @(negedge clk);
      tick();
      reset = 1'b1;
      repeat (12) begin
         @(negedge clk);
         check("abort_no_ready", {bus.ready_o, bus.rvalid_o}, '0);
      end
      read_line(32'h80);
      read_line(32'h40);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
